// File: rtl/gap_pkg.sv
// Shared types and elaboration helpers for the global average pooling stage.
package gap_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } gap_state_e;

  function automatic int calc_acc_w(input int width, input int num_pixels);
    return width + $clog2(num_pixels);
  endfunction

  // Reciprocal of the pixel count, rounded to nearest at the given scale.
  function automatic int calc_recip(input int shift, input int num_pixels);
    return ((32'sd1 <<< shift) + (num_pixels / 32'sd2)) / num_pixels;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/gap_scale.sv
// Product stage of the drain pipeline: registered multiply by the reciprocal,
// then shift (round half-up when GAP_ROUND_EN is defined) and saturate.
module gap_scale
  import gap_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_PIXELS  = 49,
  parameter int RECIP_SHIFT = 16,
  parameter int CH_W        = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       stall,
  input  logic                                       in_valid,
  input  logic [CH_W-1:0]                            in_ch,
  input  logic [calc_acc_w(WIDTH, NUM_PIXELS)-1:0]   acc_in,
  output logic                                       out_valid,
  output logic [CH_W-1:0]                            out_ch,
  output logic [WIDTH-1:0]                           avg
);

  localparam int ACC_W = calc_acc_w(WIDTH, NUM_PIXELS);
  localparam int P_W   = ACC_W + RECIP_SHIFT + 1;
  localparam logic signed [P_W-1:0] RECIP_S = P_W'(calc_recip(RECIP_SHIFT, NUM_PIXELS));
  localparam logic signed [P_W-1:0] HALF_S  =
    {{(P_W - RECIP_SHIFT){1'b0}}, 1'b1, {(RECIP_SHIFT - 1){1'b0}}};

  logic signed [P_W-1:0] acc_ext_s;
  logic signed [P_W-1:0] prod_r;
  logic signed [P_W-1:0] rnd_s;
  logic signed [P_W-1:0] shifted_s;
  logic                  valid_r;
  logic [CH_W-1:0]       ch_r;

  assign acc_ext_s = P_W'($signed(acc_in));

  // product register, held while the output register cannot take a new value
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r  <= '0;
      valid_r <= 1'b0;
      ch_r    <= '0;
    end else if (!stall) begin
      prod_r  <= acc_ext_s * RECIP_S;
      valid_r <= in_valid;
      ch_r    <= in_ch;
    end
  end

`ifdef GAP_ROUND_EN
  assign rnd_s = prod_r + HALF_S;
`else
  assign rnd_s = prod_r;
`endif

  assign shifted_s = rnd_s >>> RECIP_SHIFT;
  assign avg       = WIDTH'(saturate(64'(shifted_s), WIDTH));
  assign out_valid = valid_r;
  assign out_ch    = ch_r;

endmodule

// File: rtl/gap_accumulator.sv
// Global average pooling: per-channel sums over a frame, then one averaged
// sample per channel drained in order. Define GAP_ROUND_EN for round half-up.
module gap_accumulator
  import gap_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8,
  parameter int CHANNELS    = 576,
  parameter int NUM_PIXELS  = 49,
  parameter int RECIP_SHIFT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [$clog2(CHANNELS)-1:0]   ch_out,
  output logic                          frame_done
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int PIX_W = $clog2(NUM_PIXELS);
  localparam int ACC_W = calc_acc_w(WIDTH, NUM_PIXELS);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

  // FRAC only describes the format; the average keeps it unchanged.
  if (FRAC >= WIDTH) begin : g_frac_chk
    $error("gap_accumulator: FRAC must be smaller than WIDTH");
  end

  gap_state_e             state_r;
  gap_state_e             state_s;
  logic [CH_W-1:0]        ch_cnt_r;
  logic [PIX_W-1:0]       pix_cnt_r;
  logic [CH_W-1:0]        drain_ch_r;
  logic                   issue_done_r;
  logic                   ready_in_r;
  logic                   valid_out_r;
  logic [WIDTH-1:0]       data_out_r;
  logic [CH_W-1:0]        ch_out_r;
  logic                   frame_done_r;
  logic signed [ACC_W-1:0] acc_r [CHANNELS];
  logic signed [ACC_W-1:0] acc_base_s;
  logic [ACC_W-1:0]       acc_rd_s;

  logic                   accept_s;
  logic                   last_in_s;
  logic                   advance_s;
  logic                   issue_s;
  logic                   last_out_s;
  logic                   scale_valid_s;
  logic [CH_W-1:0]        scale_ch_s;
  logic [WIDTH-1:0]       scale_avg_s;

  assign accept_s   = valid_in && ready_in_r;
  assign last_in_s  = accept_s && (ch_cnt_r == CH_LAST) && (pix_cnt_r == PIX_LAST);
  assign advance_s  = !valid_out_r || ready_out;
  assign issue_s    = (state_r == DRAIN) && advance_s && !issue_done_r;
  assign last_out_s = valid_out_r && ready_out && (ch_out_r == CH_LAST);
  assign acc_rd_s   = acc_r[drain_ch_r];

  // next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (last_in_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ACCUM;
        end
      end
      DRAIN: begin
        if (last_out_s) begin
          state_s = ACCUM;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = ACCUM;
    endcase
  end

  // state, input-ready and frame-done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ACCUM;
      ready_in_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      ready_in_r   <= (state_s == ACCUM);
      frame_done_r <= last_out_s;
    end
  end

  // channel/pixel counters for accumulation and the drain issue pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_r     <= '0;
      pix_cnt_r    <= '0;
      drain_ch_r   <= '0;
      issue_done_r <= 1'b0;
    end else if (state_r == ACCUM) begin
      drain_ch_r   <= '0;
      issue_done_r <= 1'b0;
      if (accept_s) begin
        if (ch_cnt_r == CH_LAST) begin
          ch_cnt_r  <= '0;
          pix_cnt_r <= (pix_cnt_r == PIX_LAST) ? PIX_W'(0) : pix_cnt_r + PIX_W'(1);
        end else begin
          ch_cnt_r <= ch_cnt_r + CH_W'(1);
        end
      end
    end else if (issue_s) begin
      if (drain_ch_r == CH_LAST) begin
        issue_done_r <= 1'b1;
      end else begin
        drain_ch_r <= drain_ch_r + CH_W'(1);
      end
    end
  end

  // pixel 0 overwrites the sum, so no separate clear pass is needed
  always_comb begin
    if (pix_cnt_r == PIX_W'(0)) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_r[ch_cnt_r];
    end
  end

  // per-channel accumulator storage
  always_ff @(posedge clk) begin
    if (accept_s) begin
      acc_r[ch_cnt_r] <= acc_base_s + ACC_W'($signed(data_in));
    end
  end

  gap_scale #(
    .WIDTH       (WIDTH),
    .NUM_PIXELS  (NUM_PIXELS),
    .RECIP_SHIFT (RECIP_SHIFT),
    .CH_W        (CH_W)
  ) u_scale (
    .clk       (clk),
    .rst       (rst),
    .stall     (!advance_s),
    .in_valid  (issue_s),
    .in_ch     (drain_ch_r),
    .acc_in    (acc_rd_s),
    .out_valid (scale_valid_s),
    .out_ch    (scale_ch_s),
    .avg       (scale_avg_s)
  );

  // output register; holds while valid_out is stalled by ready_out
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_r <= 1'b0;
      data_out_r  <= '0;
      ch_out_r    <= '0;
    end else if ((state_r == DRAIN) && advance_s) begin
      valid_out_r <= scale_valid_s;
      if (scale_valid_s) begin
        data_out_r <= scale_avg_s;
        ch_out_r   <= scale_ch_s;
      end
    end
  end

  assign ready_in   = ready_in_r;
  assign valid_out  = valid_out_r;
  assign data_out   = data_out_r;
  assign ch_out     = ch_out_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_gap_accumulator.sv
// Directed, table-driven bench for gap_accumulator with CHANNELS=4, NUM_PIXELS=49.
module tb_gap_accumulator;

`ifdef GAP_ROUND_EN
  localparam logic [15:0] E_ONE = 16'h0100;
  localparam logic [15:0] E_MAX = 16'h7FF4;   // 32756
  localparam logic [15:0] E_MIN = 16'h800C;   // -32756
`else
  localparam logic [15:0] E_ONE = 16'h00FF;
  localparam logic [15:0] E_MAX = 16'h7FF3;   // 32755
  localparam logic [15:0] E_MIN = 16'h800B;   // -32757
`endif

  typedef struct packed {
    logic [3:0][15:0] ins;       // {ch3, ch2, ch1, ch0}
    logic [3:0][15:0] exps;
    logic             bubbles;
    logic             garbage;
    logic signed [7:0] bp_ch;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic [1:0]  ch_out;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  vec_t vecs [5];

  gap_accumulator #(
    .WIDTH(16), .FRAC(8), .CHANNELS(4), .NUM_PIXELS(49), .RECIP_SHIFT(16)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .ch_out(ch_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic feed(input logic [3:0][15:0] ins, input logic bubbles, input int npix);
    for (int p = 0; p < npix; p++) begin
      for (int c = 0; c < 4; c++) begin
        int w;
        w = 0;
        data_in  = ins[c];
        valid_in = 1'b1;
        while (!ready_in && w < 50) begin
          @(negedge clk);
          w++;
        end
        if (w >= 50) begin
          fail("feed_wait");
          valid_in = 1'b0;
          return;
        end
        @(negedge clk);
        last_acc = cyc;
        valid_in = 1'b0;
        if (bubbles) begin
          data_in = 16'h5A5A;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic drain(input logic [3:0][15:0] exps, input logic signed [7:0] bp_ch,
                       input logic garbage);
    int idx, t, bp_left;
    bit first, held, done;
    logic [15:0] hd;
    logic [1:0]  hc;
    idx = 0; t = 0; bp_left = 5; first = 1'b1; held = 1'b0; done = 1'b0;
    hd = 16'h0000; hc = 2'd0;
    ready_out = 1'b1;
    if (garbage) begin
      data_in  = 16'h7FFF;
      valid_in = 1'b1;
    end
    while (!done && t < 200) begin
      if (frame_done) begin
        valid_in = 1'b0;
        check("ready_in_at_done", 32'(ready_in), 32'd1);
        check("valid_out_at_done", 32'(valid_out), 32'd0);
        check("channels_emitted", 32'(idx), 32'd4);
        done = 1'b1;
      end else begin
        check("ready_in_drain", 32'(ready_in), 32'd0);
        if (held) begin
          check("hold_valid", 32'(valid_out), 32'd1);
          check("hold_data", 32'(data_out), 32'(hd));
          check("hold_ch", 32'(ch_out), 32'(hc));
          held = 1'b0;
        end
        if (valid_out) begin
          if (first) begin
            check("first_latency", 32'(cyc - last_acc), 32'd2);
            first = 1'b0;
          end
          if (bp_ch >= 0 && int'(ch_out) == int'(bp_ch) && bp_left > 0) begin
            ready_out = 1'b0;
            hd = data_out;
            hc = ch_out;
            held = 1'b1;
            bp_left--;
          end else begin
            ready_out = 1'b1;
            if (idx < 4) begin
              check("data_out", 32'(data_out), 32'(exps[idx]));
              check("ch_out", 32'(ch_out), 32'(idx));
            end else begin
              fail("extra_output");
            end
            idx++;
          end
        end else begin
          ready_out = 1'b1;
        end
        @(negedge clk);
        t++;
      end
    end
    valid_in = 1'b0;
    if (!done) begin
      fail("drain_wait");
    end
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 32'd0);
    check("valid_out_idle", 32'(valid_out), 32'd0);
  endtask

  initial begin
    vecs[0] = '{ins: {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                exps: {E_ONE, E_ONE, E_ONE, E_ONE}, bubbles: 1'b0, garbage: 1'b0, bp_ch: -8'sd1};
    vecs[1] = '{ins: {16'h7FFF, 16'h0000, 16'hFF00, 16'h0100},
                exps: {E_MAX, 16'h0000, 16'hFF00, E_ONE}, bubbles: 1'b0, garbage: 1'b0, bp_ch: 8'sd1};
    vecs[2] = '{ins: {16'h8000, 16'h8000, 16'h8000, 16'h8000},
                exps: {E_MIN, E_MIN, E_MIN, E_MIN}, bubbles: 1'b0, garbage: 1'b0, bp_ch: -8'sd1};
    vecs[3] = '{ins: {16'h0100, 16'h0100, 16'h0100, 16'h0100},
                exps: {E_ONE, E_ONE, E_ONE, E_ONE}, bubbles: 1'b1, garbage: 1'b1, bp_ch: -8'sd1};
    vecs[4] = '{ins: {16'h7FFF, 16'h0000, 16'hFF00, 16'h0100},
                exps: {E_MAX, 16'h0000, 16'hFF00, E_ONE}, bubbles: 1'b0, garbage: 1'b0, bp_ch: -8'sd1};

    rst = 1'b1; valid_in = 1'b0; data_in = 16'h0000; ready_out = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready_in", 32'(ready_in), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_in_rise", 32'(ready_in), 32'd1);

    for (int v = 0; v < 5; v++) begin
      feed(vecs[v].ins, vecs[v].bubbles, 49);
      drain(vecs[v].exps, vecs[v].bp_ch, vecs[v].garbage);
    end

    // mid-frame reset: partial sums of 0x7FFF must not leak into the next frame
    feed({16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 1'b0, 20);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_ready_in", 32'(ready_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid_out", 32'(valid_out), 32'd0);
    check("postrst_ready_in", 32'(ready_in), 32'd1);
    feed({16'h0100, 16'h0100, 16'h0100, 16'h0100}, 1'b0, 49);
    drain({E_ONE, E_ONE, E_ONE, E_ONE}, -8'sd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
